// File: rtl/nms_window_buf_pkg.sv
// Shared definitions for the NMS neighbourhood window buffer.
// Window-size encodings and slot indexing helpers.
package nms_window_buf_pkg;

    localparam int SCORE_LSB = 0;
    localparam int CORNER_BIT = 13;

    typedef enum logic [1:0] {
        WIN_SEL_3 = 2'd0,
        WIN_SEL_5 = 2'd1,
        WIN_SEL_7 = 2'd2,
        WIN_SEL_X = 2'd3
    } win_sel_e;

    // Window edge length for a selector, clamped to the buffer size.
    function automatic logic [2:0] win_size(
        input logic [1:0] sel,
        input int win_max
    );
        int w;
        w = 3 + 2 * int'(sel);
        if (w > win_max) w = win_max;
        return 3'(w);
    endfunction

    // Flat slot index inside the output window bus.
    function automatic int win_idx(
        input int r,
        input int c,
        input int win_max
    );
        return r * win_max + c;
    endfunction

endpackage

// File: rtl/nms_window_buf_if.sv
// Pixel-in / window-out bundle of the NMS window buffer.
// master = score producer side, slave = window buffer.
interface nms_window_buf_if #(
    parameter int DATA_W  = 34,
    parameter int WIN_MAX = 5,
    parameter int ADDR_W  = 10
);
    logic [1:0]                        win_sel;
    logic                              sof;
    logic                              in_vld;
    logic [DATA_W-1:0]                 in_data;
    logic                              out_vld;
    logic [WIN_MAX*WIN_MAX*DATA_W-1:0] out_win;
    logic [ADDR_W-1:0]                 out_x;
    logic [ADDR_W-1:0]                 out_y;
    logic [2:0]                        out_win_sz;

    modport master (
        output win_sel, sof, in_vld, in_data,
        input  out_vld, out_win, out_x, out_y, out_win_sz
    );

    modport slave (
        input  win_sel, sof, in_vld, in_data,
        output out_vld, out_win, out_x, out_y, out_win_sz
    );
endinterface

// File: rtl/nms_window_buf_line_ram.sv
// One line of pixel storage, read-before-write at the same address.
// Read is asynchronous so the old word joins the window on the write beat.
module nms_window_buf_line_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 34,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              hit;
    logic [AW-1:0]     a;

    assign hit   = addr < ADDR_W'(DEPTH);
    assign a     = addr[AW-1:0];
    assign rdata = hit ? mem[a] : '0;

    // Store the incoming pixel on every accepted beat.
    always_ff @(posedge clk) begin
        if (ce && hit) mem[a] <= wdata;
    end
endmodule

// File: rtl/nms_window_buf.sv
// NMS neighbourhood buffer: line storage plus a WIN x WIN shift window.
// Emits one window per interior centre with its coordinates.
module nms_window_buf
    import nms_window_buf_pkg::*;
#(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int SCORE_W = 13,
    parameter int DATA_W  = 34,
    parameter int WIN_MAX = 5,
    parameter int ADDR_W  = 10
) (
    input logic           clk,
    input logic           rst,
    input logic           ce,
    nms_window_buf_if.slave bus
);
    localparam int NL = WIN_MAX - 1;

    logic              accept;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [2:0]        rows_filled;
    logic              synced;
    logic [2:0]        win;

    logic [ADDR_W-1:0] x_cur;
    logic [ADDR_W-1:0] y_cur;
    logic [2:0]        win_cur;
    logic [2:0]        half_cur;
    logic [2:0]        rf_cur;
    logic              sync_cur;
    logic              last_col;
    logic              last_row;
    logic              emit;

    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] line_d  [NL];
    logic [DATA_W-1:0] line_q  [NL];
    logic [DATA_W-1:0] col_new [WIN_MAX];
    logic [DATA_W-1:0] sh      [WIN_MAX][WIN_MAX];

    assign accept   = ce & bus.in_vld;
    assign x_cur    = bus.sof ? '0 : col;
    assign y_cur    = bus.sof ? '0 : row;
    assign win_cur  = bus.sof ? win_size(bus.win_sel, WIN_MAX) : win;
    assign half_cur = (win_cur - 3'd1) >> 1;
    assign rf_cur   = bus.sof ? 3'd0 : rows_filled;
    assign sync_cur = bus.sof | synced;
    assign last_col = x_cur == ADDR_W'(COL_NUM - 1);
    assign last_row = y_cur == ADDR_W'(ROW_NUM - 1);

    assign emit = accept & sync_cur
                & (x_cur >= ADDR_W'(win_cur) - ADDR_W'(1))
                & (rf_cur >= win_cur - 3'd1);

    // Non-corner pixels carry no score into the neighbourhood.
    always_comb begin
        pix = bus.in_data;
        if (!bus.in_data[SCORE_W]) pix[SCORE_W:0] = '0;
    end

    // New window column: oldest line on top, live pixel at the bottom.
    always_comb begin
        col_new[WIN_MAX-1] = pix;
        for (int r = 0; r < WIN_MAX - 1; r++) begin
            col_new[r] = line_q[WIN_MAX-2-r];
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_line
        if (k == 0) begin : g_first
            assign line_d[k] = pix;
        end else begin : g_next
            assign line_d[k] = line_q[k-1];
        end

        nms_window_buf_line_ram #(
            .DEPTH  (COL_NUM),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .ce    (accept),
            .addr  (x_cur),
            .wdata (line_d[k]),
            .rdata (line_q[k])
        );
    end

    // Pixel position, fill depth since sof and latched window size.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            rows_filled <= '0;
            synced      <= 1'b0;
            win         <= 3'd3;
        end else if (accept) begin
            synced <= sync_cur;
            win    <= win_cur;
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : y_cur + ADDR_W'(1);
                if (last_row) begin
                    rows_filled <= '0;
                end else if (rf_cur != 3'(NL)) begin
                    rows_filled <= rf_cur + 3'd1;
                end else begin
                    rows_filled <= rf_cur;
                end
            end else begin
                col         <= x_cur + ADDR_W'(1);
                row         <= y_cur;
                rows_filled <= rf_cur;
            end
        end
    end

    // Shift the window left by one column per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIN_MAX; r++) begin
                for (int c = 0; c < WIN_MAX; c++) begin
                    sh[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN_MAX; r++) begin
                for (int c = 0; c < WIN_MAX - 1; c++) begin
                    sh[r][c] <= sh[r][c+1];
                end
                sh[r][WIN_MAX-1] <= col_new[r];
            end
        end
    end

    // Valid strobe and centre coordinates, one cycle after the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_vld <= 1'b0;
            bus.out_x   <= '0;
            bus.out_y   <= '0;
        end else begin
            bus.out_vld <= emit;
            if (emit) begin
                bus.out_x <= x_cur - ADDR_W'(half_cur);
                bus.out_y <= y_cur - ADDR_W'(half_cur);
            end
        end
    end

    assign bus.out_win_sz = win;

    // Active window sits in the bottom-right of the shift array.
    always_comb begin
        bus.out_win = '0;
        for (int w = 3; w <= WIN_MAX; w += 2) begin
            if (win == 3'(w)) begin
                for (int r = 0; r < w; r++) begin
                    for (int c = 0; c < w; c++) begin
                        bus.out_win[win_idx(r, c, WIN_MAX)*DATA_W +: DATA_W] =
                            sh[r+WIN_MAX-w][c+WIN_MAX-w];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nms_window_buf.sv
// Directed bench for nms_window_buf on a small 8x6 frame.
// Expected windows come from a pixel model and the interior-centre rule.
module tb_nms_window_buf;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int SW   = 13;
    localparam int DW   = 34;
    localparam int WM   = 7;
    localparam int AW   = 10;

    typedef struct {
        int cx;
        int cy;
        int w;
        int mx;
        int my;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    nms_window_buf_if #(.DATA_W(DW), .WIN_MAX(WM), .ADDR_W(AW)) bus ();

    nms_window_buf #(
        .COL_NUM (COLS),
        .ROW_NUM (ROWS),
        .SCORE_W (SW),
        .DATA_W  (DW),
        .WIN_MAX (WM),
        .ADDR_W  (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    exp_t q[$];
    int   n_err  = 0;
    int   n_chk  = 0;
    int   pulses = 0;
    int   base;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Stored (masked) pixel word for (x,y); (mx,my) is the non-corner pixel.
    function automatic logic [DW-1:0] word(int x, int y, int mx, int my);
        logic [19:0] aux;
        aux = 20'h80000 | 20'(y << 4) | 20'(x);
        if (x == mx && y == my) return {aux, 1'b0, 13'd0};
        return {aux, 1'b1, 13'(y * COLS + x)};
    endfunction

    // Raw input word: a non-corner pixel still carries its score.
    function automatic logic [DW-1:0] raw(int x, int y, int mx, int my);
        logic [DW-1:0] d;
        d = word(x, y, -1, -1);
        if (x == mx && y == my) d[SW] = 1'b0;
        return d;
    endfunction

    task automatic push_exp(int n, int w, int mx, int my);
        int h;
        h = (w - 1) / 2;
        for (int i = 0; i < n; i++) begin
            int x;
            int y;
            x = i % COLS;
            y = i / COLS;
            if (x >= w - 1 && y >= w - 1) q.push_back('{x - h, y - h, w, mx, my});
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic s, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    ce          = 1'b0;
                    bus.in_vld  = 1'b1;
                end else begin
                    ce          = 1'b1;
                    bus.in_vld  = 1'b0;
                end
                bus.sof     = 1'b1;
                bus.in_data = DW'({$urandom(), $urandom()});
                @(posedge clk);
                #1;
            end
        end
        ce          = 1'b1;
        bus.in_vld  = 1'b1;
        bus.sof     = s;
        bus.in_data = d;
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        bus.sof    = 1'b0;
    endtask

    // Send n pixels of a frame; win_sel changes after beat 0 and must be ignored.
    task automatic frame(int n, bit use_sof, int sel, int mx, int my, bit gaps);
        bus.win_sel = 2'(sel);
        for (int i = 0; i < n; i++) begin
            beat(raw(i % COLS, i / COLS, mx, my), use_sof && i == 0, gaps);
            if (i == 0) bus.win_sel = 2'(sel + 1);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vld"}, 64'(bus.out_vld), 0);
        check({tag, "_x"}, 64'(bus.out_x), 0);
        check({tag, "_y"}, 64'(bus.out_y), 0);
        check({tag, "_sz"}, 64'(bus.out_win_sz), 3);
        check({tag, "_win"}, 64'(|bus.out_win), 0);
    endtask

    initial begin
        rst         = 1'b1;
        ce          = 1'b0;
        bus.in_vld  = 1'b0;
        bus.sof     = 1'b0;
        bus.win_sel = 2'd0;
        bus.in_data = '0;
        fork
            begin : driver
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check_reset("rst");

                base = pulses;
                push_exp(48, 3, -1, -1);
                frame(48, 1'b1, 0, -1, -1, 1'b0);
                settle();
                check("s1_cnt", 64'(pulses - base), 24);

                base = pulses;
                push_exp(48, 3, 3, 3);
                frame(48, 1'b1, 0, 3, 3, 1'b0);
                settle();
                check("s2_cnt", 64'(pulses - base), 24);

                base = pulses;
                push_exp(48, 5, -1, -1);
                frame(48, 1'b1, 1, -1, -1, 1'b0);
                settle();
                check("s3_cnt", 64'(pulses - base), 8);

                base = pulses;
                push_exp(48, 3, -1, -1);
                frame(48, 1'b1, 0, -1, -1, 1'b1);
                settle();
                check("s4_cnt", 64'(pulses - base), 24);

                base = pulses;
                push_exp(29, 3, -1, -1);
                frame(29, 1'b1, 0, -1, -1, 1'b0);
                push_exp(48, 3, -1, -1);
                frame(48, 1'b1, 0, -1, -1, 1'b0);
                settle();
                check("s5_cnt", 64'(pulses - base), 33);

                base = pulses;
                push_exp(20, 3, -1, -1);
                frame(20, 1'b1, 0, -1, -1, 1'b0);
                rst = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                check_reset("mid_rst");
                rst = 1'b0;
                frame(48, 1'b0, 0, -1, -1, 1'b0);
                settle();
                check("s6_nosof_cnt", 64'(pulses - base), 2);
                push_exp(48, 3, -1, -1);
                frame(48, 1'b1, 0, -1, -1, 1'b0);
                settle();
                check("s6_cnt", 64'(pulses - base), 26);
            end
            begin : monitor
                exp_t        e;
                logic        acc;
                logic [DW-1:0] want;
                int          h;
                forever begin
                    @(posedge clk);
                    acc = ce && bus.in_vld;
                    @(negedge clk);
                    if (!acc) check("vld_no_beat", 64'(bus.out_vld), 0);
                    if (bus.out_vld) begin
                        if (q.size() == 0) begin
                            check("extra_vld", 64'(bus.out_vld), 0);
                        end else begin
                            e = q.pop_front();
                            pulses++;
                            h = (e.w - 1) / 2;
                            check("out_x", 64'(bus.out_x), 64'(e.cx));
                            check("out_y", 64'(bus.out_y), 64'(e.cy));
                            check("out_sz", 64'(bus.out_win_sz), 64'(e.w));
                            for (int r = 0; r < WM; r++) begin
                                for (int c = 0; c < WM; c++) begin
                                    want = '0;
                                    if (r < e.w && c < e.w)
                                        want = word(e.cx - h + c, e.cy - h + r,
                                                    e.mx, e.my);
                                    check($sformatf("slot_%0d_%0d@%0d,%0d",
                                                    r, c, e.cx, e.cy),
                                          64'(bus.out_win[(r*WM+c)*DW +: DW]),
                                          64'(want));
                                end
                            end
                        end
                    end
                end
            end
        join_any
        disable fork;
        check("pending", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
